kbd_fifo: RTL and testbench

- Buffered keyboard front-end between the ps2 receiver (done/data strobe) and the CPU port bus.
- Queues scancodes in a small FIFO and serves port 0x60 (data) and port 0x61 (status/control).
- Issues one interrupt-request pulse per queued byte to the interrupt arbiter (vector 9 path).
- Prevents scancode loss when the CPU is slow to acknowledge IRQ 1.

---
 rtl/kbd_fifo_pkg.sv | 26 ++
 rtl/kbd_fifo_if.sv | 35 +++
 rtl/kbd_fifo_sync_fifo.sv | 62 ++++++
 rtl/kbd_fifo.sv | 162 ++++++++++++++++
 tb/tb_kbd_fifo.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_fifo_pkg.sv
// kbd_pkg: constants and types shared by the keyboard front-end.
//   - Port addresses for the data (0x60) and status/control (0x61) ports.
//   - Bit positions of the flush command and the overflow status flag.
//   - Encoding of the interrupt-request state machine.
//   - A helper that clips a fill level to the 5-bit status field.
package kbd_pkg;

  localparam logic [15:0] KBD_PORT_DATA = 16'h0060;
  localparam logic [15:0] KBD_PORT_STAT = 16'h0061;

  localparam int KBD_FLUSH_BIT = 7;
  localparam int KBD_OVF_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } irq_state_t;

  // The status byte only has room for five count bits; larger fill
  // levels saturate instead of wrapping.
  function automatic logic [4:0] clip5(input logic [31:0] n);
    return (n > 32'd31) ? 5'd31 : n[4:0];
  endfunction

endpackage

// File: rtl/kbd_fifo_if.sv
// kbd_fifo_if: bundle of the keyboard front-end's bus-side signals.
//   kb_done/kb_data      ps2 receiver strobe and scancode
//   port_a/port_r/port_w CPU port address, read and write strobes
//   port_o               CPU write data
//   port_i/port_hit      registered read data and its valid flag
//   irq_req              one-cycle interrupt request pulse
//   count                current FIFO fill level
// master: the side that drives the strobes (receiver + CPU).
// slave:  the keyboard front-end itself.
interface kbd_fifo_if #(
  parameter int AW = 4
);

  logic          kb_done;
  logic [7:0]    kb_data;
  logic [15:0]   port_a;
  logic          port_r;
  logic          port_w;
  logic [7:0]    port_o;
  logic [7:0]    port_i;
  logic          port_hit;
  logic          irq_req;
  logic [AW:0]   count;

  modport master (
    output kb_done, kb_data, port_a, port_r, port_w, port_o,
    input  port_i, port_hit, irq_req, count
  );

  modport slave (
    input  kb_done, kb_data, port_a, port_r, port_w, port_o,
    output port_i, port_hit, irq_req, count
  );

endinterface

// File: rtl/kbd_fifo_sync_fifo.sv
// sync_fifo: byte FIFO storage and pointers for the keyboard front-end.
//   clock, reset  system clock, synchronous active-high reset
//   push, din     write din at the tail (caller guarantees room)
//   pop, dout     advance the head; dout always shows the head byte
//   flush         empty the FIFO at the next edge, overriding push/pop
//   count         fill level 0..DEPTH
//   full, empty   fill-level flags
// The head is read asynchronously from the array so that a read strobe
// can return the head byte with a single cycle of latency.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // only moves when exactly one of push/pop is active.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; stale contents are never visible because the
  // count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/kbd_fifo.sv
// kbd_fifo: buffered keyboard front-end between the ps2 receiver and the
// CPU port bus.
//   clock  system clock (25 MHz domain)
//   reset  synchronous, active-high reset
//   bus    kbd_fifo_if slave modport:
//            kb_done/kb_data in, port_a/port_r/port_w/port_o in,
//            port_i/port_hit out (registered), irq_req out (pulse),
//            count out (fill level)
// Port 0x60 returns the oldest queued scancode (or the last one popped
// when the queue is empty); port 0x61 returns {overflow, 00, count} on
// read and flushes the queue on a write with bit 7 set. One irq_req pulse
// is raised per byte, with a dead cycle after each pop so the arbiter sees
// a fresh edge for the next byte.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic     clock,
  input  logic     reset,
  kbd_fifo_if.slave bus
);

  logic          rd_data;
  logic          rd_stat;
  logic          wr_flush;
  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic [7:0]    head;
  logic [AW:0]   fifo_count;
  logic [AW:0]   count_next;
  logic          full;
  logic          empty;
  logic [7:0]    stat_byte;

  logic [7:0]    port_i_q;
  logic          port_hit_q;
  logic          overflow_q;
  logic [7:0]    last_q;

  irq_state_t    state_q;
  irq_state_t    state_d;
  logic          irq_q;
  logic          irq_d;

  // Decode the port strobes and qualify push/pop. A pop needs a byte to
  // take; a push into a full queue is still legal when a pop frees a slot
  // in the same cycle. A flush discards anything arriving alongside it.
  always_comb begin
    rd_data    = bus.port_r && (bus.port_a == KBD_PORT_DATA);
    rd_stat    = bus.port_r && (bus.port_a == KBD_PORT_STAT);
    wr_flush   = bus.port_w && (bus.port_a == KBD_PORT_STAT) &&
                 bus.port_o[KBD_FLUSH_BIT];
    do_pop     = rd_data && !empty && !wr_flush;
    do_push    = bus.kb_done && !wr_flush && (!full || do_pop);
    drop       = bus.kb_done && !wr_flush && full && !do_pop;

    count_next = fifo_count;
    if (wr_flush) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = fifo_count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = fifo_count - 1'b1;
    end

    stat_byte              = '0;
    stat_byte[4:0]         = clip5(32'(fifo_count));
    stat_byte[KBD_OVF_BIT] = overflow_q;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .flush (wr_flush),
    .din   (bus.kb_data),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // Port read data, the last-popped byte and the sticky overflow flag.
  // A drop in the same cycle as a status read keeps overflow set so the
  // lost byte is still reported on the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      port_i_q   <= '0;
      port_hit_q <= 1'b0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      port_hit_q <= rd_data || rd_stat;
      if (rd_data) begin
        port_i_q <= empty ? last_q : head;
      end else if (rd_stat) begin
        port_i_q <= stat_byte;
      end
      if (do_pop) last_q <= head;
      if (wr_flush) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end else if (rd_stat) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Interrupt state register and the registered request pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  // Request when a byte will be present after this edge, wait for the
  // CPU to pop it, then idle one cycle before re-requesting for any
  // remaining byte. A flush abandons the outstanding request.
  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_next != '0) begin
          irq_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (do_pop) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (wr_flush) begin
      state_d = IDLE;
      irq_d   = 1'b0;
    end
  end

  assign bus.port_i   = port_i_q;
  assign bus.port_hit = port_hit_q;
  assign bus.irq_req  = irq_q;
  assign bus.count    = fifo_count;

endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: self-checking bench for kbd_fifo.
// A table of single-cycle vectors covers port decode, read-data muxing,
// empty reads and the IRQ handshake; hand-written sequences cover the
// IRQ spacing, a full queue with overflow, flush and mid-operation reset.
module tb_kbd_fifo;

  logic clock;
  logic reset;

  int vectors;
  int miscompares;
  int irq_seen;

  kbd_fifo_if #(.AW(4)) bus ();

  kbd_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 25 MHz clock
  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  typedef struct {
    string       name;
    logic        kb_done;
    logic [7:0]  kb_data;
    logic [15:0] port_a;
    logic        port_r;
    logic        port_w;
    logic [7:0]  port_o;
    logic [7:0]  exp_port_i;
    logic        exp_hit;
    logic        exp_irq;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t makeVec(input string name, input logic kd,
                                   input logic [7:0] kdata, input logic [15:0] a,
                                   input logic r, input logic w, input logic [7:0] o,
                                   input logic [7:0] ei, input logic eh,
                                   input logic eq, input logic [4:0] ec);
    vec_t v;
    v.name = name; v.kb_done = kd; v.kb_data = kdata; v.port_a = a;
    v.port_r = r; v.port_w = w; v.port_o = o; v.exp_port_i = ei;
    v.exp_hit = eh; v.exp_irq = eq; v.exp_count = ec;
    return v;
  endfunction

  // One clock edge; outputs are sampled 1 time unit after it and any
  // irq pulse is tallied.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.irq_req === 1'b1) irq_seen++;
  endtask

  task automatic setInputs(input logic kd, input logic [7:0] kdata,
                           input logic [15:0] a, input logic r,
                           input logic w, input logic [7:0] o);
    bus.kb_done = kd;
    bus.kb_data = kdata;
    bus.port_a  = a;
    bus.port_r  = r;
    bus.port_w  = w;
    bus.port_o  = o;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.kb_done, v.kb_data, v.port_a, v.port_r, v.port_w, v.port_o);
    tick();
    checkOutput($sformatf("%s.port_i", v.name), 32'(bus.port_i), 32'(v.exp_port_i));
    checkOutput($sformatf("%s.port_hit", v.name), 32'(bus.port_hit), 32'(v.exp_hit));
    checkOutput($sformatf("%s.irq_req", v.name), 32'(bus.irq_req), 32'(v.exp_irq));
    checkOutput($sformatf("%s.count", v.name), 32'(bus.count), 32'(v.exp_count));
  endtask

  task automatic idle();
    setInputs(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    setInputs(1'b1, d, 16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic readPort(input logic [15:0] a);
    setInputs(1'b0, 8'h00, a, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    irq_seen    = 0;
    reset       = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("reset.count", 32'(bus.count), 0);
    checkOutput("reset.irq_req", 32'(bus.irq_req), 0);
    checkOutput("reset.port_hit", 32'(bus.port_hit), 0);
    checkOutput("reset.port_i", 32'(bus.port_i), 0);
    reset = 1'b0;

    // name, kb_done, kb_data, port_a, port_r, port_w, port_o,
    // expected port_i, port_hit, irq_req, count
    vecs.push_back(makeVec("idle0",     0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(makeVec("push1C",    1, 8'h1C, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 1, 1));
    vecs.push_back(makeVec("wait1",     0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(makeVec("rd60_1C",   0, 8'h00, 16'h0060, 1, 0, 8'h00, 8'h1C, 1, 0, 0));
    vecs.push_back(makeVec("hold1C",    0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h1C, 0, 0, 0));
    vecs.push_back(makeVec("rd61_emp",  0, 8'h00, 16'h0061, 1, 0, 8'h00, 8'h00, 1, 0, 0));
    vecs.push_back(makeVec("rd60_emp",  0, 8'h00, 16'h0060, 1, 0, 8'h00, 8'h1C, 1, 0, 0));
    vecs.push_back(makeVec("push9C",    1, 8'h9C, 16'h0000, 0, 0, 8'h00, 8'h1C, 0, 1, 1));
    vecs.push_back(makeVec("rd60_9C",   0, 8'h00, 16'h0060, 1, 0, 8'h00, 8'h9C, 1, 0, 0));
    vecs.push_back(makeVec("gap9C",     0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h9C, 0, 0, 0));
    vecs.push_back(makeVec("rd60_last", 0, 8'h00, 16'h0060, 1, 0, 8'h00, 8'h9C, 1, 0, 0));
    vecs.push_back(makeVec("rd61_zero", 0, 8'h00, 16'h0061, 1, 0, 8'h00, 8'h00, 1, 0, 0));
    vecs.push_back(makeVec("rd_other",  0, 8'h00, 16'h0064, 1, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(makeVec("pp_empty",  1, 8'h5A, 16'h0060, 1, 0, 8'h00, 8'h9C, 1, 1, 1));
    vecs.push_back(makeVec("rd61_one",  0, 8'h00, 16'h0061, 1, 0, 8'h00, 8'h01, 1, 0, 1));
    vecs.push_back(makeVec("wr61_noop", 0, 8'h00, 16'h0061, 0, 1, 8'h00, 8'h01, 0, 0, 1));
    vecs.push_back(makeVec("rd60_5A",   0, 8'h00, 16'h0060, 1, 0, 8'h00, 8'h5A, 1, 0, 0));
    vecs.push_back(makeVec("idle_end",  0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h5A, 0, 0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Two queued bytes: the second request follows the first pop plus
    // the dead cycle.
    begin
      int waited;
      bit got;
      irq_seen = 0;
      push(8'hF0); tick();
      push(8'h1C); tick();
      idle();      tick();
      readPort(16'h0060); tick();
      checkOutput("two.first_byte", 32'(bus.port_i), 32'h F0);
      checkOutput("two.first_hit", 32'(bus.port_hit), 1);
      idle();
      waited = 0;
      got    = 1'b0;
      for (int n = 1; n <= 4 && !got; n++) begin
        tick();
        waited = n;
        if (bus.irq_req === 1'b1) got = 1'b1;
      end
      checkOutput("two.irq_seen_in_time", 32'(got), 1);
      checkOutput("two.irq_delay", 32'(waited), 2);
      readPort(16'h0060); tick();
      checkOutput("two.second_byte", 32'(bus.port_i), 32'h1C);
      checkOutput("two.count", 32'(bus.count), 0);
      idle(); tick(); tick(); tick();
      checkOutput("two.irq_pulses", 32'(irq_seen), 2);
    end

    // Fill past capacity, status with and without overflow, push+pop
    // while full, then drain in order.
    for (int i = 1; i <= 17; i++) begin
      push(8'(i)); tick();
    end
    checkOutput("full.count", 32'(bus.count), 16);
    readPort(16'h0061); tick();
    checkOutput("full.stat_ovf", 32'(bus.port_i), 32'h90);
    checkOutput("full.stat_hit", 32'(bus.port_hit), 1);
    readPort(16'h0061); tick();
    checkOutput("full.stat_clr", 32'(bus.port_i), 32'h10);
    setInputs(1'b1, 8'h77, 16'h0060, 1'b1, 1'b0, 8'h00); tick();
    checkOutput("full.pp_byte", 32'(bus.port_i), 32'h01);
    checkOutput("full.pp_count", 32'(bus.count), 16);
    readPort(16'h0061); tick();
    checkOutput("full.pp_no_ovf", 32'(bus.port_i), 32'h10);
    for (int i = 2; i <= 16; i++) begin
      readPort(16'h0060); tick();
      checkOutput($sformatf("drain.byte%0d", i), 32'(bus.port_i), 32'(i));
    end
    readPort(16'h0060); tick();
    checkOutput("drain.byte77", 32'(bus.port_i), 32'h77);
    checkOutput("drain.count", 32'(bus.count), 0);
    idle(); tick(); tick(); tick();

    // Flush while overflowed and waiting on an irq, with a scancode
    // arriving in the same cycle.
    for (int i = 0; i < 17; i++) begin
      push(8'hA0 + 8'(i)); tick();
    end
    setInputs(1'b1, 8'hEE, 16'h0061, 1'b0, 1'b1, 8'h80); tick();
    checkOutput("flush.count", 32'(bus.count), 0);
    checkOutput("flush.irq", 32'(bus.irq_req), 0);
    irq_seen = 0;
    idle(); tick(); tick(); tick();
    checkOutput("flush.no_irq", 32'(irq_seen), 0);
    readPort(16'h0061); tick();
    checkOutput("flush.stat", 32'(bus.port_i), 32'h00);
    readPort(16'h0060); tick();
    checkOutput("flush.last", 32'(bus.port_i), 32'h77);
    push(8'h44); tick();
    checkOutput("flush.new_irq", 32'(bus.irq_req), 1);

    // Reset while waiting on the irq for 0x44.
    reset = 1'b1;
    push(8'h55); tick();
    checkOutput("rst.count", 32'(bus.count), 0);
    checkOutput("rst.irq", 32'(bus.irq_req), 0);
    checkOutput("rst.port_i", 32'(bus.port_i), 0);
    reset = 1'b0;
    readPort(16'h0060); tick();
    checkOutput("rst.last", 32'(bus.port_i), 0);
    push(8'h66); tick();
    checkOutput("rst.irq_after", 32'(bus.irq_req), 1);
    checkOutput("rst.count_after", 32'(bus.count), 1);
    readPort(16'h0060); tick();
    checkOutput("rst.byte66", 32'(bus.port_i), 32'h66);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
